// File: rtl/paddle_control.sv
// Left/right paddle centre positions: synchronised, debounced buttons move each
// paddle by STEP on a divided tick, clamped to the walls, and a score change recentres both.
module paddle_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MOVE_DIV        = 100000,
    parameter logic [9:0]  STEP            = 10'd2,
    parameter logic [9:0]  Y_MIN           = 10'd95,
    parameter logic [9:0]  Y_MAX           = 10'd455,
    parameter logic [9:0]  Y_CENTER        = 10'd275
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnUpLeft,
    input  logic       btnDownLeft,
    input  logic       btnUpRight,
    input  logic       btnDownRight,
    input  logic [3:0] scoreLeft,
    input  logic [3:0] scoreRight,
    output logic [9:0] yposLeft,
    output logic [9:0] yposRight
);

    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0] TICK_LAST = 20'(MOVE_DIV - 1);

    // Button order: bit0 up-left, bit1 down-left, bit2 up-right, bit3 down-right.
    logic [3:0]       raw_s;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d;
    logic [3:0][19:0] cnt_q, cnt_d;
    logic [19:0]      tick_cnt_q, tick_cnt_d;
    logic             tick_s;
    logic [3:0]       score_l_q, score_r_q;
    logic             recentre_s;
    logic [9:0]       y_l_q, y_l_d, y_r_q, y_r_d;

    assign raw_s = {btnDownRight, btnUpRight, btnDownLeft, btnUpLeft};

    // Clamped move computed in 11 bits so "y - STEP" near the top wall cannot wrap.
    function automatic logic [9:0] move_paddle(input logic [9:0] y,
                                               input logic up,
                                               input logic dn);
        logic [10:0] y_ext;
        logic [10:0] lo_ext;
        logic [10:0] sum_ext;
        y_ext   = {1'b0, y};
        lo_ext  = {1'b0, Y_MIN} + {1'b0, STEP};
        sum_ext = y_ext + {1'b0, STEP};
        if (up && !dn) begin
            if (y_ext >= lo_ext) move_paddle = y - STEP;
            else                 move_paddle = Y_MIN;
        end else if (dn && !up) begin
            if (sum_ext > {1'b0, Y_MAX}) move_paddle = Y_MAX;
            else                         move_paddle = sum_ext[9:0];
        end else begin
            move_paddle = y;
        end
    endfunction

    // Per-button debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int b = 0; b < 4; b++) begin
            if (sync2_q[b] != db_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    db_d[b]  = sync2_q[b];
                    cnt_d[b] = 20'd0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 20'd1;
                end
            end else begin
                cnt_d[b] = 20'd0;
            end
        end
    end

    // Free-running movement divider and paddle next-state with recentre priority.
    always_comb begin
        tick_s     = (tick_cnt_q == TICK_LAST);
        recentre_s = (scoreLeft != score_l_q) || (scoreRight != score_r_q);
        if (tick_s) tick_cnt_d = 20'd0;
        else        tick_cnt_d = tick_cnt_q + 20'd1;
        if (recentre_s) begin
            y_l_d = Y_CENTER;
            y_r_d = Y_CENTER;
        end else if (tick_s) begin
            y_l_d = move_paddle(y_l_q, db_q[0], db_q[1]);
            y_r_d = move_paddle(y_r_q, db_q[2], db_q[3]);
        end else begin
            y_l_d = y_l_q;
            y_r_d = y_r_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 4'd0;
            sync2_q    <= 4'd0;
            db_q       <= 4'd0;
            cnt_q      <= '0;
            tick_cnt_q <= 20'd0;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            y_l_q      <= Y_CENTER;
            y_r_q      <= Y_CENTER;
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            score_l_q  <= scoreLeft;
            score_r_q  <= scoreRight;
            y_l_q      <= y_l_d;
            y_r_q      <= y_r_d;
        end
    end

    assign yposLeft  = y_l_q;
    assign yposRight = y_r_q;

endmodule
